// File: rtl/display_scanner_pkg.sv
// Shared types and constants for the 4-digit multiplexed display scanner.
package display_pkg;

    localparam int         NUM_DIGITS = 4;
    localparam logic [3:0] ANODES_OFF = 4'b1111;

    typedef logic [3:0] digit_t;
    typedef logic [1:0] idx_t;

    // Active-low one-hot anode pattern for a digit index.
    function automatic logic [NUM_DIGITS-1:0] anode_sel(input idx_t i);
        return ~(4'b0001 << i);
    endfunction

endpackage

// File: rtl/display_scanner_if.sv
// Host-side bundle: value/strobe/controls in, decoder and anode drive out.
interface display_scanner_if;
    import display_pkg::*;

    logic [15:0] value;
    logic        load;
    logic [3:0]  dp_in;
    logic        blank_lz;
    logic [2:0]  brightness;
    digit_t      number;
    logic [3:0]  anodes;
    logic        dp_n;
    logic        frame_done;

    modport master (
        output value, load, dp_in, blank_lz, brightness,
        input  number, anodes, dp_n, frame_done
    );

    modport slave (
        input  value, load, dp_in, blank_lz, brightness,
        output number, anodes, dp_n, frame_done
    );

endinterface

// File: rtl/display_scanner_scan_timer.sv
// Slot prescaler and digit index counter for the display scanner.
module scan_timer
    import display_pkg::*;
#(
    parameter int CLK_DIV = 50000,
    localparam int PW = $clog2(CLK_DIV)
) (
    input  logic          clk,
    input  logic          rst,
    output logic [PW-1:0] pc,
    output idx_t          idx,
    output logic          slot_end,
    output logic          frame_end
);

    assign slot_end  = (pc == PW'(CLK_DIV - 1));
    assign frame_end = slot_end && (idx == idx_t'(NUM_DIGITS - 1));

    // Prescaler wraps at the slot end and steps the digit index along.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc  <= '0;
            idx <= '0;
        end else if (slot_end) begin
            pc  <= '0;
            idx <= idx + 2'd1;
        end else begin
            pc  <= pc + 1'b1;
        end
    end

endmodule

// File: rtl/display_scanner.sv
// Four-digit multiplexed display scanner: tear-free shadow/display registers,
// leading-zero blanking, brightness PWM and registered drive outputs.
module display_scanner
    import display_pkg::*;
#(
    parameter int CLK_DIV = 50000
) (
    input  logic             clk,
    input  logic             rst,
    display_scanner_if.slave bus
);

    localparam int PW    = $clog2(CLK_DIV);
    localparam int SLOT8 = CLK_DIV / 8;

    logic [PW-1:0] pc;
    idx_t          idx;
    logic          slot_end;
    logic          frame_end;
    logic          boundary;

    logic [15:0] shadow_val, disp_val;
    logic [3:0]  shadow_dp,  disp_dp;

    digit_t      cur_nib;
    logic [3:0]  lz_zero;
    logic        blanked;
    logic [31:0] on_lim;
    logic        pwm_on;
    logic        lit;

    digit_t      number_q;
    logic [3:0]  anodes_q;
    logic        dp_n_q;
    logic        frame_done_q;

    scan_timer #(.CLK_DIV(CLK_DIV)) u_timer (
        .clk       (clk),
        .rst       (rst),
        .pc        (pc),
        .idx       (idx),
        .slot_end  (slot_end),
        .frame_end (frame_end)
    );

    // Frame boundary is always the last cycle of a slot.
    assign boundary = slot_end & frame_end;

    // Shadow takes every load; display only moves at the frame boundary,
    // with a same-cycle load bypassing straight into it.
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_val <= '0;
            shadow_dp  <= '0;
            disp_val   <= '0;
            disp_dp    <= '0;
        end else begin
            if (bus.load) begin
                shadow_val <= bus.value;
                shadow_dp  <= bus.dp_in;
            end
            if (boundary) begin
                disp_val <= bus.load ? bus.value : shadow_val;
                disp_dp  <= bus.load ? bus.dp_in : shadow_dp;
            end
        end
    end

    // Current nibble, leading-zero chain and PWM window for this slot.
    always_comb begin
        cur_nib    = disp_val[{idx, 2'b00} +: 4];
        lz_zero    = '0;
        lz_zero[3] = (disp_val[15:12] == 4'h0);
        lz_zero[2] = lz_zero[3] && (disp_val[11:8] == 4'h0);
        lz_zero[1] = lz_zero[2] && (disp_val[7:4] == 4'h0);
        blanked    = bus.blank_lz && lz_zero[idx];
        on_lim     = (32'(bus.brightness) + 32'd1) * 32'(SLOT8);
        pwm_on     = (pc != '0) && (32'(pc) < on_lim);
        lit        = pwm_on && !blanked;
    end

    // Output stage: one register between counter state and the pins.
    always_ff @(posedge clk) begin
        if (rst) begin
            number_q     <= '0;
            anodes_q     <= ANODES_OFF;
            dp_n_q       <= 1'b1;
            frame_done_q <= 1'b0;
        end else begin
            number_q     <= cur_nib;
            anodes_q     <= lit ? anode_sel(idx) : ANODES_OFF;
            dp_n_q       <= lit ? ~disp_dp[idx] : 1'b1;
            frame_done_q <= frame_end;
        end
    end

    assign bus.number     = number_q;
    assign bus.anodes     = anodes_q;
    assign bus.dp_n       = dp_n_q;
    assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_display_scanner.sv
// Bench for display_scanner with CLK_DIV = 16: directed scenarios plus a
// randomized tail, all checked cycle by cycle against an arithmetic model.
module tb_display_scanner;
    import display_pkg::*;

    localparam int DIV   = 16;
    localparam int FRAME = 4 * DIV;

    logic clk = 1'b0;
    logic rst;

    display_scanner_if bus ();

    display_scanner #(.CLK_DIV(DIV)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Model: mt counts non-reset cycles since the last reset.
    int          mt;
    logic [15:0] sh_v, dsp_v;
    logic [3:0]  sh_dp, dsp_dp;
    logic [3:0]  e_num, e_an;
    logic        e_dp, e_fd;

    task automatic step();
        bit          r, ld, lz, lit;
        logic [15:0] v;
        logic [3:0]  dpi;
        int          br, pcv, ix;
        r   = rst;
        ld  = bus.load;
        lz  = bus.blank_lz;
        v   = bus.value;
        dpi = bus.dp_in;
        br  = int'(bus.brightness);
        @(posedge clk);
        if (r) begin
            mt = 0; sh_v = '0; sh_dp = '0; dsp_v = '0; dsp_dp = '0;
            e_num = 4'h0; e_an = 4'hF; e_dp = 1'b1; e_fd = 1'b0;
        end else begin
            pcv   = mt % DIV;
            ix    = (mt / DIV) % 4;
            e_num = 4'(dsp_v >> (4 * ix));
            lit   = (pcv != 0) && (pcv < (br + 1) * (DIV / 8))
                    && !(lz && ix != 0 && (dsp_v >> (4 * ix)) == 16'h0);
            e_an  = lit ? ~(4'b0001 << ix) : 4'hF;
            e_dp  = lit ? ~dsp_dp[ix] : 1'b1;
            e_fd  = (pcv == DIV - 1) && (ix == 3);
            if (e_fd) begin
                dsp_v  = ld ? v   : sh_v;
                dsp_dp = ld ? dpi : sh_dp;
            end
            if (ld) begin
                sh_v  = v;
                sh_dp = dpi;
            end
            mt++;
        end
        #1;
        n_cmp++;
        assert (bus.number === e_num) else begin
            n_bad++;
            $error("FAIL number mt=%0d got %h want %h", mt, bus.number, e_num);
        end
        n_cmp++;
        assert (bus.anodes === e_an) else begin
            n_bad++;
            $error("FAIL anodes mt=%0d got %b want %b", mt, bus.anodes, e_an);
        end
        n_cmp++;
        assert (bus.dp_n === e_dp) else begin
            n_bad++;
            $error("FAIL dp_n mt=%0d got %b want %b", mt, bus.dp_n, e_dp);
        end
        n_cmp++;
        assert (bus.frame_done === e_fd) else begin
            n_bad++;
            $error("FAIL frame_done mt=%0d got %b want %b", mt, bus.frame_done, e_fd);
        end
        n_cmp++;
        assert ($countones(~bus.anodes) <= 1) else begin
            n_bad++;
            $error("FAIL onehot mt=%0d got %b want at most one low", mt, bus.anodes);
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Advance until the model's next pre-edge frame position equals pos.
    task automatic wait_pos(input int pos);
        for (int i = 0; i < FRAME && (mt % FRAME) != pos; i++) step();
    endtask

    task automatic load_pulse(input logic [15:0] v, input logic [3:0] dp);
        bus.value = v;
        bus.dp_in = dp;
        bus.load  = 1'b1;
        step();
        bus.load  = 1'b0;
        bus.value = 16'($urandom);
        bus.dp_in = 4'($urandom);
    endtask

    initial begin
        logic [15:0] rv;
        rst            = 1'b1;
        bus.value      = '0;
        bus.load       = 1'b0;
        bus.dp_in      = '0;
        bus.blank_lz   = 1'b0;
        bus.brightness = 3'd7;
        mt             = 0;

        // reset, release, then reset again mid-scan with a pending load
        run(3);
        rst = 1'b0;
        run(40);
        load_pulse(16'hBEEF, 4'hF);
        run(5);
        rst = 1'b1;
        run(3);
        rst = 1'b0;
        run(FRAME + 4);

        // scan order
        load_pulse(16'h12AB, 4'h0);
        run(3 * FRAME);

        // leading-zero blanking
        bus.blank_lz = 1'b1;
        load_pulse(16'h0050, 4'h0);
        run(2 * FRAME);
        load_pulse(16'h0000, 4'h0);
        run(2 * FRAME);

        // tear-free load mid-frame, then load on the boundary cycle
        bus.blank_lz = 1'b0;
        load_pulse(16'h2222, 4'h0);
        run(2 * FRAME);
        wait_pos(20);
        load_pulse(16'h1111, 4'h0);
        run(FRAME);
        wait_pos(FRAME - 1);
        load_pulse(16'h3456, 4'h5);
        run(FRAME);

        // brightness levels and on-the-fly changes
        bus.brightness = 3'd0;
        run(FRAME);
        bus.brightness = 3'd3;
        run(FRAME);
        for (int i = 0; i < 2 * FRAME; i++) begin
            bus.brightness = 3'($urandom_range(0, 7));
            step();
        end
        bus.brightness = 3'd7;

        // decimal point, including a request on a blanked digit
        bus.blank_lz = 1'b1;
        load_pulse(16'h0A00, 4'b0100);
        run(2 * FRAME);
        load_pulse(16'h0A00, 4'b1100);
        run(2 * FRAME);

        // randomized tail
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 499) == 0) rst = 1'b1;
            else if (rst && $urandom_range(0, 1) == 0) rst = 1'b0;
            if ($urandom_range(0, 49) == 0) bus.brightness = 3'($urandom);
            if ($urandom_range(0, 99) == 0) bus.blank_lz = ~bus.blank_lz;
            rv = 16'($urandom);
            case ($urandom_range(0, 3))
                0: rv = rv & 16'h000F;
                1: rv = rv & 16'h00FF;
                2: rv = rv & 16'h0FFF;
                default: ;
            endcase
            bus.value = rv;
            bus.dp_in = 4'($urandom);
            bus.load  = ($urandom_range(0, 19) == 0);
            step();
        end
        bus.load = 1'b0;
        rst      = 1'b0;
        run(FRAME);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/display_scanner.md
# display_scanner

Four-digit multiplexed display scanner, directly upstream of the 7-segment decoder. Takes a 16-bit hex value (PC, register or bus word from the core) and time-multiplexes it onto a common-anode 4-digit display. Drives the decoder's 4-bit `number` input, plus the active-low digit anodes and decimal point. Provides tear-free value updates, leading-zero blanking and 8-level brightness control.

## Interface
- `CLK_DIV`, 50000: clock cycles per digit slot. Must be a multiple of 8 and ≥ 16; 50 MHz gives a 250 Hz frame.
- `clk` input 1: system clock. One clock domain.
- `rst` input 1: reset, synchronous, active-high.
- `value` input 16: hex value to display; digit i = `value[4i+3:4i]`, digit 0 rightmost.
- `load` input 1: single-cycle strobe; capture `value` and `dp_in` into the shadow register.
- `dp_in` input 4: decimal point request per digit, 1 = lit.
- `blank_lz` input 1: 1 = blank leading zero digits (level, sampled every cycle).
- `brightness` input 3: on-time per slot = (brightness+1)/8 of the slot, minus ghost cycle.
- `number` output 4: nibble for the decoder (feeds `segments.number`).
- `anodes` output 4: digit enables, active-low, one-hot-low or all-high.
- `dp_n` output 1: decimal point, active-low.
- `frame_done` output 1: one-cycle pulse at the end of digit 3's slot.

## Operation
- **Prescaler `pc`.**
  - Counts 0..CLK_DIV-1, then wraps to 0.
  - At `pc == CLK_DIV-1`, the digit index `idx` advances 0→1→2→3→0.
  - `frame_done` = 1 in the cycle where `pc == CLK_DIV-1` and `idx == 3`.
- **Shadow register.** `load` writes `{value, dp_in}` into the shadow register; the last load wins.
- **Display register.**
  - Copied from the shadow register at the frame boundary (the cycle `frame_done` is high).
  - If `load` coincides with the boundary, the new `value`/`dp_in` go straight into both registers (bypass).
  - The display register never changes mid-frame, so there is no tearing.
- **Anode enable.** For the current `idx`, the anode is driven when both hold:
  - `pc != 0` (one ghost-blank cycle per slot);
  - `pc < (brightness+1)*(CLK_DIV/8)`.
  - Otherwise `anodes = 4'b1111`. `brightness` is sampled every cycle.
- **Leading-zero blanking** (when `blank_lz = 1`):
  - digit 3 is blanked if its nibble is 0;
  - digit 2 is blanked if nibbles 3 and 2 are 0;
  - digit 1 is blanked if nibbles 3, 2 and 1 are 0;
  - digit 0 is never blanked, so the value 0 shows "0".
  - A blanked digit forces its anode high and `dp_n = 1`.
- **Number output.** `number` always carries the display-register nibble for `idx`, even while blanked. The decoder stays purely combinational.
- **Decimal point.** `dp_n = ~dp[idx]` while the anode is driven; 1 otherwise.

## Timing
- `number`, `anodes`, `dp_n` and `frame_done` are registered. They reflect the counter state (`idx`, `pc`) of the previous cycle: a fixed 1-cycle latency.
- **Reset values** (`rst` high at a rising edge):
  - `pc = 0`, `idx = 0`;
  - shadow and display registers = 0;
  - `number = 4'h0`, `anodes = 4'b1111`, `dp_n = 1`, `frame_done = 0`.
- **After reset release:** the first slot is digit 0. Its anode first goes low at output cycle 2 (cycle `pc == 1`, plus 1 register stage).
- **Reset mid-frame:** everything returns to the reset state on the next edge. A pending shadow value is discarded.
- **Load timing:** a `load` in frame N appears from the first slot of frame N+1. The boundary-cycle bypass also lands in frame N+1.
- **Anodes:** never more than one anode low in any cycle, including at `idx` wrap and while `brightness` changes.

## Structure
- **Package `display_pkg`:**
  - `NUM_DIGITS = 4`;
  - `ANODES_OFF = 4'b1111`;
  - the `digit_t` (4-bit) typedef;
  - a function giving the one-hot-low anode for an index.
- **Sub-module `scan_timer`:**
  - contains the prescaler and `idx` counter;
  - outputs `pc`, `idx`, `slot_end`, `frame_end`;
  - parameter `CLK_DIV`.
- The top level holds the shadow/display registers, blanking, brightness compare and output registers. The `segments` decoder is instantiated by the board top, not inside this block.

## Test plan
All scenarios use CLK_DIV = 16.
- **Reset.** Hold `rst` for 3 cycles mid-scan → `anodes = 1111`, `number = 0`, `dp_n = 1`. After release, `anodes = 1110` from output cycle 2 to 16.
- **Scan order.** Load `16'h12AB`, `brightness = 7`, `blank_lz = 0`. In the second frame, `number` sequence is B, A, 2, 1 with anodes 1110, 1101, 1011, 0111. Each is low for 15 cycles, high for 1. `frame_done` pulses every 64 cycles.
- **Leading zeros.** Load `16'h0050`, `blank_lz = 1` → digits 3 and 2 keep anodes high; digits 1 ("5") and 0 ("0") are lit. Load `16'h0000` → only digit 0 is lit.
- **Tear-free load.** Load `16'h1111` during digit 1's slot → the rest of the frame still shows the old value. The next frame shows 1111. A load in the `frame_done` cycle shows in the very next slot.
- **Brightness.** `brightness = 0` → each anode is low for exactly 1 cycle per slot (pc = 1). `brightness = 3` → low for 7 cycles. Check that at most one anode is low at any time.
- **Decimal point.** `dp_in = 4'b0100`, `blank_lz = 1`, value `16'h0A00` → `dp_n = 0` only during digit 2's lit cycles. On a blanked digit, `dp_n` stays 1 even when its `dp_in` bit is 1.
